// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serialiser with one-entry holding buffer (parity via UART_TX_PARITY_EN)
module uart_transmitter #(
   parameter int BYTE_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  tick,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [BYTE_WIDTH-1:0] data_in,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int IDX_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_WIDTH - 1);
   localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [1:0]            stop_q, stop_d;
   logic [BYTE_WIDTH-1:0] shift_q, shift_d;
   logic [BYTE_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  bit_end;
   logic                  load;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   assign tx_ready = !hold_full_q;
   assign tx       = tx_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

   // Next-state, buffer, counters and the registered pin level decoded from the next state
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      stop_d      = stop_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      done_d      = 1'b0;
      load        = 1'b0;
      tx_d        = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      bit_end = (state_q != S_IDLE) && tick && (cnt_q == CNT_LAST);

      // Ticks only advance the bit timer while a frame is on the line
      if ((state_q != S_IDLE) && tick) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (hold_full_q) begin
               load = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
                  stop_d  = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               stop_d  = '0;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  done_d = 1'b1;
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Loading from the holding buffer restarts the bit timer at a fresh start bit
      if (load) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         cnt_d       = '0;
         state_d     = S_START;
`ifdef UART_TX_PARITY_EN
         parity_d    = ^hold_q;
`endif
      end

      // A full buffer refuses writes, so load and accept never coincide
      if (tx_valid && !hold_full_q) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State register; reset returns the line to idle-high immediately
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         stop_q      <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         stop_q      <= stop_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int OS      = 16;
   localparam int FRAME_T = (1 + 8 + PB + 1) * OS;
   localparam int FRAME2  = (1 + 8 + PB + 2) * OS;

   logic       clk = 1'b0;
   logic       arst_n = 1'b1;
   logic       tick = 1'b0;
   logic       valid1 = 1'b0, valid2 = 1'b0;
   logic [7:0] din1 = 8'h00, din2 = 8'h00;
   logic       ready1, tx1, busy1, done1;
   logic       ready2, tx2, busy2, done2;

   always #5 clk = ~clk;

   uart_transmitter #(.BYTE_WIDTH(8), .OVERSAMPLE(OS), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .arst_n(arst_n), .tick(tick), .tx_valid(valid1), .tx_ready(ready1),
      .data_in(din1), .tx(tx1), .tx_busy(busy1), .tx_done(done1));

   uart_transmitter #(.BYTE_WIDTH(8), .OVERSAMPLE(OS), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .arst_n(arst_n), .tick(tick), .tx_valid(valid2), .tx_ready(ready2),
      .data_in(din2), .tx(tx2), .tx_busy(busy2), .tx_done(done2));

   int total = 0;
   int bad = 0;

   // Reference model: each frame is a list of line levels indexed by tick number
   bit         m_busy[2], m_full[2], m_level[2], m_done[2], m_acc[2];
   logic [7:0] m_hold[2];
   bit         m_wave[2][0:255];
   int         m_pos[2], m_len[2];

   // Bench-side observation of DUT frames
   int   tick_div = 0;
   bit   stall = 1'b0, rnd_tick = 1'b0;
   bit   bp0 = 1'b0, bp1 = 1'b0, txp2 = 1'b1;
   int   meas0 = 0, meas1 = 0, z1 = 0, o1 = 0;
   int   frame_ticks0 = 0, frame_ticks1 = 0, cap_z = 0, cap_o = 0;
   bit   got_done0 = 1'b0, got_done1 = 1'b0;
   logic rec0[0:11];

   typedef struct {
      logic [7:0]  din;
      logic [11:0] bits;
      int          nbits;
      int          ticks;
      int          stall_at;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0; m_full[i] = 0; m_level[i] = 1; m_done[i] = 0; m_acc[i] = 0;
         m_pos[i] = 0; m_len[i] = 0;
      end
   endfunction

   function automatic void m_load(input int i);
      bit fb[0:12];
      int nb, tot;
      nb = 0;
      fb[nb++] = 1'b0;
      for (int b = 0; b < 8; b++) fb[nb++] = m_hold[i][b];
      if (PB == 1) fb[nb++] = ^m_hold[i];
      for (int s = 0; s < i + 1; s++) fb[nb++] = 1'b1;
      tot = nb * OS;
      for (int k = 1; k < tot; k++) m_wave[i][k] = fb[k / OS];
      m_len[i]   = tot - 1;
      m_pos[i]   = 1;
      m_level[i] = 1'b0;
      m_busy[i]  = 1'b1;
      m_full[i]  = 1'b0;
   endfunction

   function automatic void m_step(input int i, input logic v, input logic [7:0] d);
      m_acc[i]  = v && !m_full[i];
      m_done[i] = 1'b0;
      if (m_busy[i]) begin
         if (tick) begin
            if (m_pos[i] <= m_len[i]) begin
               m_level[i] = m_wave[i][m_pos[i]];
               m_pos[i]++;
            end else begin
               m_done[i] = 1'b1;
               if (m_full[i]) m_load(i);
               else begin
                  m_busy[i]  = 1'b0;
                  m_level[i] = 1'b1;
               end
            end
         end
      end else if (m_full[i]) begin
         m_load(i);
      end
      if (m_acc[i]) begin
         m_hold[i] = d;
         m_full[i] = 1'b1;
      end
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (arst_n) begin
         m_step(0, valid1, din1);
         m_step(1, valid2, din2);
      end else begin
         m_done[0] = 0; m_done[1] = 0; m_acc[0] = 0; m_acc[1] = 0;
      end
      if (tick && bp0) meas0++;
      if (tick && bp1) begin
         meas1++;
         if (txp2) o1++; else z1++;
      end
      @(negedge clk);
      chk("tx0", tx1, m_level[0]);
      chk("busy0", busy1, m_busy[0]);
      chk("done0", done1, m_done[0]);
      chk("ready0", ready1, !m_full[0]);
      chk("tx1", tx2, m_level[1]);
      chk("busy1", busy2, m_busy[1]);
      chk("done1", done2, m_done[1]);
      chk("ready1", ready2, !m_full[1]);
      if (busy1 && (meas0 % OS == OS / 2) && (meas0 / OS < 12)) rec0[meas0 / OS] = tx1;
      if (done1) begin
         got_done0 = 1'b1; frame_ticks0 = meas0; meas0 = 0;
      end
      if (done2) begin
         got_done1 = 1'b1; frame_ticks1 = meas1; cap_z = z1; cap_o = o1;
         meas1 = 0; z1 = 0; o1 = 0;
      end
      bp0  = busy1;
      bp1  = busy2;
      txp2 = tx2;
      tick_div = (tick_div + 1) % 4;
      if (rnd_tick) tick = ($urandom_range(0, 2) == 0) && !stall;
      else          tick = (tick_div == 0) && !stall;
   endtask

   task automatic send0(input logic [7:0] d);
      valid1 = 1'b1;
      din1   = d;
      for (int n = 0; n < 100; n++) begin
         cycle();
         if (m_acc[0]) break;
      end
      chk("accept0", m_acc[0], 1'b1);
      valid1 = 1'b0;
      din1   = 8'($urandom);
   endtask

   task automatic wait_done0();
      for (int n = 0; n < 4000; n++) begin
         if (got_done0) break;
         cycle();
      end
      chk("done0 seen", got_done0, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      got_done0 = 1'b0;
      for (int b = 0; b < 12; b++) rec0[b] = 1'bx;
      send0(v.din);
      if (v.stall_at >= 0) begin
         for (int n = 0; n < 3000 && meas0 < v.stall_at; n++) cycle();
         stall = 1'b1;
         tick  = 1'b0;
         repeat (100) cycle();
         chk("stall tx", tx1, 1'b0);
         stall = 1'b0;
      end
      wait_done0();
      chk("frame ticks", frame_ticks0, v.ticks);
      for (int b = 0; b < v.nbits; b++) chk("frame bit", rec0[b], v.bits[b]);
      repeat (5) cycle();
   endtask

   initial begin
      vec_t vff;
`ifdef UART_TX_PARITY_EN
      vecs[0] = '{8'h07, 12'b011000001110, 11, FRAME_T, -1};
      vecs[1] = '{8'h03, 12'b010000000110, 11, FRAME_T, -1};
      vecs[2] = '{8'hA5, 12'b010101001010, 11, FRAME_T, -1};
      vecs[3] = '{8'h80, 12'b011100000000, 11, FRAME_T, 6 * OS + 8};
      vecs[4] = '{8'h00, 12'b010000000000, 11, FRAME_T, -1};
      vff     = '{8'hFF, 12'b010111111110, 11, FRAME_T, -1};
`else
      vecs[0] = '{8'hA5, 12'b001101001010, 10, FRAME_T, -1};
      vecs[1] = '{8'h55, 12'b001010101010, 10, FRAME_T, -1};
      vecs[2] = '{8'h0F, 12'b001000011110, 10, FRAME_T, -1};
      vecs[3] = '{8'h80, 12'b001100000000, 10, FRAME_T, 6 * OS + 8};
      vecs[4] = '{8'h00, 12'b001000000000, 10, FRAME_T, -1};
      vff     = '{8'hFF, 12'b001111111110, 10, FRAME_T, -1};
`endif
      m_reset();
      #1 arst_n = 1'b0;
      repeat (3) cycle();
      chk("rst tx", tx1, 1'b1);
      chk("rst ready", ready1, 1'b1);
      chk("rst busy", busy1, 1'b0);
      chk("rst done", done1, 1'b0);
      arst_n = 1'b1;
      repeat (4) cycle();

      // Single frames from the table, including the tick stall case
      for (int v = 0; v < 5; v++) run_vec(vecs[v]);

      // Back-to-back: second byte waits in the buffer and follows with no gap
      got_done0 = 1'b0;
      valid1 = 1'b1; din1 = 8'h55;
      for (int n = 0; n < 100; n++) begin cycle(); if (m_acc[0]) break; end
      chk("b2b accept1", m_acc[0], 1'b1);
      din1 = 8'h0F;
      for (int n = 0; n < 100; n++) begin cycle(); if (m_acc[0]) break; end
      chk("b2b accept2", m_acc[0], 1'b1);
      valid1 = 1'b0; din1 = 8'hC3;
      chk("b2b ready held", ready1, 1'b0);
      wait_done0();
      chk("b2b gap tx", tx1, 1'b0);
      chk("b2b busy", busy1, 1'b1);
      chk("b2b ticks1", frame_ticks0, FRAME_T);
      got_done0 = 1'b0;
      wait_done0();
      chk("b2b ticks2", frame_ticks0, FRAME_T);
      repeat (5) cycle();

      // Reset during data bit 3 of 0x3C, then a clean 0xFF frame
      got_done0 = 1'b0;
      send0(8'h3C);
      for (int n = 0; n < 3000 && meas0 < 4 * OS + 8; n++) cycle();
      #2 arst_n = 1'b0;
      #1;
      chk("mid rst tx", tx1, 1'b1);
      chk("mid rst ready", ready1, 1'b1);
      chk("mid rst busy", busy1, 1'b0);
      m_reset();
      meas0 = 0; meas1 = 0; z1 = 0; o1 = 0;
      repeat (3) cycle();
      arst_n = 1'b1;
      repeat (20) cycle();
      chk("mid rst no done", got_done0, 1'b0);
      run_vec(vff);

      // Two stop bits on the second instance
      got_done1 = 1'b0;
      valid2 = 1'b1; din2 = 8'h00;
      for (int n = 0; n < 100; n++) begin cycle(); if (m_acc[1]) break; end
      chk("sb2 accept", m_acc[1], 1'b1);
      valid2 = 1'b0;
      for (int n = 0; n < 4000 && !got_done1; n++) cycle();
      chk("sb2 done seen", got_done1, 1'b1);
      chk("sb2 ticks", frame_ticks1, FRAME2);
      chk("sb2 zeros", cap_z, FRAME2 - 2 * OS);
      chk("sb2 ones", cap_o, 2 * OS);

      // Random traffic and random tick spacing against the model
      rnd_tick = 1'b1;
      for (int n = 0; n < 9000; n++) begin
         if (!valid1 && $urandom_range(0, 7) == 0) begin valid1 = 1'b1; din1 = 8'($urandom); end
         if (!valid2 && $urandom_range(0, 7) == 0) begin valid2 = 1'b1; din2 = 8'($urandom); end
         cycle();
         if (m_acc[0]) begin valid1 = 1'b0; din1 = 8'($urandom); end
         if (m_acc[1]) begin valid2 = 1'b0; din2 = 8'($urandom); end
      end
      valid1 = 1'b0; valid2 = 1'b0;
      for (int n = 0; n < 6000; n++) begin
         if (!m_busy[0] && !m_busy[1] && !m_full[0] && !m_full[1]) break;
         cycle();
      end
      chk("drain idle", {m_busy[0], m_busy[1], busy1, busy2}, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
